// File: rtl/core_pkg.sv
// Shared RV32I core definitions: widths, constants and the fetch queue entry.
package core_pkg;

    localparam int unsigned XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order instruction queue between fetch and decode; head is read from
// registered storage, flush empties it in one cycle.
module fetch_queue
    import core_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  fetch_entry_t i_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output fetch_entry_t o_head,
    output logic [CW-1:0] o_count,
    output logic         o_empty,
    output logic         o_full
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_push_en;
    logic w_pop_en;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign w_push_en = i_push && (!o_full || i_pop);
    assign w_pop_en  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage, pointers and occupancy; flush clears pointers only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_en) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop_en) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push_en) - CW'(w_pop_en);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && o_full && !i_pop && !i_flush));

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: sequential PC generation with credit-limited requests,
// in-order response capture and redirect with stale-response dropping.
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;

    logic [CW-1:0] w_count;
    logic          w_empty;
    logic          w_full;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_data;
    logic [CW:0]   w_inflight;
    logic          w_req_valid;
    logic          w_req_fire;
    logic          w_rsp_accept;
    logic          w_rsp_keep;
    logic          w_instr_valid;
    logic          w_pop;
    logic [31:0]   w_redirect_target;
    logic [CW-1:0] w_outstanding_nxt;

    // Credits count both queued words and requests still in flight, so every
    // response is guaranteed a queue slot.
    assign w_inflight        = {1'b0, r_outstanding} + {1'b0, w_count};
    assign w_req_valid       = rst_n && !redirect_valid && (w_inflight < (CW+1)'(QUEUE_DEPTH));
    assign w_req_fire        = w_req_valid && imem_req_ready;
    assign w_rsp_accept      = imem_rsp_valid && (r_outstanding != '0);
    assign w_rsp_keep        = w_rsp_accept && !redirect_valid && (r_drop_cnt == '0);
    assign w_instr_valid     = !w_empty && !redirect_valid;
    assign w_pop             = w_instr_valid && instr_ready;
    assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign w_outstanding_nxt = r_outstanding + CW'(w_req_fire) - CW'(w_rsp_accept);
    assign w_push_data       = '{pc: r_rsp_pc, instr: imem_rsp_data};

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign instr_valid    = w_instr_valid;
    assign instr          = w_head.instr;
    assign instr_pc       = w_head.pc;

    // PC, outstanding-request and drop bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old path.
                r_fetch_pc <= w_redirect_target;
                r_rsp_pc   <= w_redirect_target;
                r_drop_cnt <= w_outstanding_nxt;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_rsp_keep) begin
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                end
                if (w_rsp_accept && (r_drop_cnt != '0)) begin
                    r_drop_cnt <= r_drop_cnt - CW'(1);
                end
            end
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_rsp_keep),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (r_outstanding != '0));

    a_push_has_room: assert property (@(posedge clk) disable iff (!rst_n)
        w_rsp_keep |-> (!w_full || w_pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order fixed-latency memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          n_fires;
    logic [31:0] pq_addr[$];
    int          pq_due[$];

    fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Memory contents are the bitwise inverse of the address.
    task automatic drive_mem();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (pq_due.size() > 0 && pq_due[0] == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~pq_addr[0];
        end
    endtask

    task automatic tick();
        if (imem_req_valid && imem_req_ready) begin
            pq_addr.push_back(imem_req_addr);
            pq_due.push_back(cyc + lat);
        end
        if (imem_rsp_valid) begin
            void'(pq_addr.pop_front());
            void'(pq_due.pop_front());
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        drive_mem();
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        pq_addr.delete();
        pq_due.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        #1;
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        drive_mem();
    endtask

    initial begin
        // 1: streaming, one instruction per cycle
        lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            #1;
            check("t1_req_valid", {31'd0, imem_req_valid}, 32'd1);
            check("t1_req_addr", imem_req_addr, 32'(4 * c));
            if (c < 2) begin
                check("t1_no_valid", {31'd0, instr_valid}, 32'd0);
            end else begin
                check("t1_valid", {31'd0, instr_valid}, 32'd1);
                check("t1_pc", instr_pc, 32'(4 * (c - 2)));
                check("t1_instr", instr, ~(32'(4 * (c - 2))));
            end
            tick();
        end

        // 2: decode stalled, credit limit, then drain and resume
        lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b0;
        do_reset();
        n_fires = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (imem_req_valid) begin
                check("t2_addr_seq", imem_req_addr, 32'(4 * n_fires));
                n_fires++;
            end
            if (c == 9) check("t2_credit_stop", {31'd0, imem_req_valid}, 32'd0);
            tick();
        end
        check("t2_fire_count", 32'(n_fires), 32'd4);
        instr_ready = 1'b1;
        for (int c = 10; c < 17; c++) begin
            #1;
            check("t2_drain_valid", {31'd0, instr_valid}, 32'd1);
            check("t2_drain_pc", instr_pc, 32'(4 * (c - 10)));
            if (c == 10) check("t2_still_blocked", {31'd0, imem_req_valid}, 32'd0);
            if (c == 11) check("t2_resume_addr", imem_req_addr, 32'h10);
            tick();
        end

        // 3: redirect with three requests in flight
        lat = 4; imem_req_ready = 1'b1; instr_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            redirect_valid = (c == 3);
            redirect_pc    = 32'h0000_0103;
            #1;
            if (c == 3) check("t3_no_req", {31'd0, imem_req_valid}, 32'd0);
            if (c == 4) check("t3_new_addr", imem_req_addr, 32'h100);
            if (c < 9) check("t3_no_stale", {31'd0, instr_valid}, 32'd0);
            if (c == 9) begin
                check("t3_first_pc", instr_pc, 32'h100);
                check("t3_first_instr", instr, ~32'h100);
            end
            if (c == 10) check("t3_second_pc", instr_pc, 32'h104);
            tick();
        end
        redirect_valid = 1'b0;

        // 4: response arriving in the redirect cycle
        lat = 2; imem_req_ready = 1'b1; instr_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            redirect_valid = (c == 3);
            redirect_pc    = 32'h0000_0200;
            #1;
            if (c == 3) begin
                check("t4_rsp_present", {31'd0, imem_rsp_valid}, 32'd1);
                check("t4_valid_masked", {31'd0, instr_valid}, 32'd0);
            end
            if (c == 4) check("t4_new_addr", imem_req_addr, 32'h200);
            if (c >= 3 && c < 7) check("t4_no_stale", {31'd0, instr_valid}, 32'd0);
            if (c == 7) begin
                check("t4_valid", {31'd0, instr_valid}, 32'd1);
                check("t4_pc", instr_pc, 32'h200);
            end
            if (c == 8) check("t4_pc2", instr_pc, 32'h204);
            tick();
        end
        redirect_valid = 1'b0;

        // 5: memory back-pressure holds the request stable
        lat = 1; imem_req_ready = 1'b0; instr_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            imem_req_ready = (c >= 5);
            #1;
            if (c <= 5) begin
                check("t5_hold_valid", {31'd0, imem_req_valid}, 32'd1);
                check("t5_hold_addr", imem_req_addr, 32'h0);
            end
            if (c == 6) check("t5_next_addr", imem_req_addr, 32'h4);
            if (c == 7) check("t5_pc0", instr_pc, 32'h0);
            if (c == 8) check("t5_pc1", instr_pc, 32'h4);
            tick();
        end

        // 6: asynchronous reset with a full queue
        lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            #1;
            tick();
        end
        #1;
        check("t6_full_valid", {31'd0, instr_valid}, 32'd1);
        check("t6_full_pc", instr_pc, 32'h0);
        check("t6_full_no_req", {31'd0, imem_req_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("t6_async_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("t6_async_req_valid", {31'd0, imem_req_valid}, 32'd0);
        instr_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            #1;
            if (c == 0) check("t6_restart_addr", imem_req_addr, 32'h0);
            if (c == 2) begin
                check("t6_restart_valid", {31'd0, instr_valid}, 32'd1);
                check("t6_restart_pc", instr_pc, 32'h0);
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
